// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared funct3 encodings, FSM states, byte-enable constants and access sizing
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] F3_SB = 2'b00;
    localparam logic [1:0] F3_SH = 2'b01;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    // Load and store funct3 share the low-bit size code; every unlisted code is a word.
    function automatic lsu_size_e size_of(input logic [1:0] f);
        return f == F3_SB ? SZ_B : f == F3_SH ? SZ_H : SZ_W;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: selects the load lane from a read word and sign/zero-extends it
module lsu_load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  ctrl,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{offset, 3'b000} +: 8];
    assign h = offset[1] ? rdata[31:16] : rdata[15:0];
    assign data = ctrl == F3_LB  ? {{24{b[7]}}, b} :
                  ctrl == F3_LBU ? {24'h0, b} :
                  ctrl == F3_LH  ? {{16{h[15]}}, h} :
                  ctrl == F3_LHU ? {16'h0, h} : rdata;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine with alignment checks and lane handling
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  loadCtrl,
    input  logic [1:0]  storeCtrl,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWData,
    output logic [3:0]  dmemByteEn,
    input  logic        dmemReady,
    input  logic [31:0] dmemRData,
    output logic        stall,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        misalignFault
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [2:0]  ld_ctrl_q, ld_ctrl_d;
    logic [31:0] ext_data, st_wdata;
    logic [3:0]  st_be;
    lsu_size_e   size;
    logic        req, misalign, accept;

    // A simultaneous read and write is treated as a store.
    assign size     = size_of(memWrite ? storeCtrl : loadCtrl[1:0]);
    assign req      = memRead | memWrite;
    assign misalign = (size == SZ_H && address[0]) || (size == SZ_W && address[1:0] != 2'b00);
    assign accept   = state_q == IDLE && req && !misalign;
    assign st_be    = size == SZ_B ? BE_BYTE << address[1:0] :
                      size == SZ_H ? BE_HALF << {address[1], 1'b0} : BE_WORD;
    assign st_wdata = size == SZ_B ? {4{storeData[7:0]}} :
                      size == SZ_H ? {2{storeData[15:0]}} : storeData;

    lsu_load_extend u_load_extend (
        .rdata  (dmemRData),
        .ctrl   (ld_ctrl_q),
        .offset (addr_q[1:0]),
        .data   (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        we_d        = we_q;
        ld_ctrl_d   = ld_ctrl_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d   = ACCESS;
                addr_d    = address;
                wdata_d   = st_wdata;
                be_d      = memWrite ? st_be : BE_WORD;
                we_d      = memWrite;
                ld_ctrl_d = loadCtrl;
            end
            ACCESS: if (dmemReady) begin
                state_d     = RESP;
                load_data_d = we_q ? load_data_q : ext_data;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            ld_ctrl_q   <= F3_LW;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            ld_ctrl_q   <= ld_ctrl_d;
            load_data_q <= load_data_d;
        end
    end

    assign dmemReq       = state_q == ACCESS;
    assign dmemWe        = we_q;
    assign dmemAddr      = {addr_q[31:2], 2'b00};
    assign dmemWData     = wdata_q;
    assign dmemByteEn    = be_q;
    assign loadData      = load_data_q;
    assign loadValid     = state_q == RESP;
    assign stall         = accept || state_q == ACCESS;
    assign misalignFault = state_q == IDLE && req && misalign;

endmodule
